// File: rtl/wb_sched_pkg.sv
// Shared types and helpers for the write-booster drain scheduler.
// Threshold compares operate on zero-extended occupancy.
package wb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } state_e;

  localparam int QUEUE_LENGTH_DEF = 4;
  localparam int CNT_W = $clog2(QUEUE_LENGTH_DEF) + 1;
  localparam int REG_W = 32;

  function automatic logic thr_ge(
    input logic [REG_W-1:0] cnt,
    input logic [REG_W-1:0] thr
  );
    return cnt >= thr;
  endfunction

  function automatic logic thr_le(
    input logic [REG_W-1:0] cnt,
    input logic [REG_W-1:0] thr
  );
    return cnt <= thr;
  endfunction

endpackage

// File: rtl/wb_drain_scheduler_if.sv
// Downstream write-request channel.
// Valid/ready handshake with a registered payload.
interface wb_drain_scheduler_if #(
  parameter int DATA_SIZE = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DATA_SIZE-1:0] req_data;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/wb_drain_scheduler.sv
// Drains the write-booster queue to the write port with hysteresis
// and flush, sharing the single queue read port with hit lookups.
module wb_drain_scheduler
  import wb_sched_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int REGISTER_SIZE = REG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          drain_enable,
  input  logic [REGISTER_SIZE-1:0]      high_threshold,
  input  logic [REGISTER_SIZE-1:0]      low_threshold,
  input  logic                          flush,
  output logic                          flush_done,
  input  logic [$clog2(QUEUE_LENGTH):0] q_count,
  input  logic                          q_empty,
  input  logic                          q_full,
  input  logic [DATA_SIZE-1:0]          q_value,
  output logic                          q_consumed,
  output logic                          q_hit,
  input  logic                          lookup_req,
  output logic                          lookup_gnt,
  wb_drain_scheduler_if.master          wr,
  output logic                          draining,
  output logic [REGISTER_SIZE-1:0]      drain_count
);

  state_e                     state_q, state_d;
  logic                       req_valid_q, req_valid_d;
  logic [DATA_SIZE-1:0]       req_data_q, req_data_d;
  logic                       draining_q, draining_d;
  logic                       pend_q, pend_d;
  logic                       done_q, done_d;
  logic [REGISTER_SIZE-1:0]   cnt_q, cnt_d;

  logic [REGISTER_SIZE-1:0]   occ;
  logic [REGISTER_SIZE-1:0]   occ_m1;
  logic                       set_c;
  logic                       clr_c;
  logic                       pend_any;
  logic                       idle_empty;
  logic                       hs;
  logic                       want;
  logic                       cont;

  assign occ    = REGISTER_SIZE'(q_count);
  assign occ_m1 = occ - REGISTER_SIZE'(1);

  assign set_c = ((high_threshold != '0) && thr_ge(occ, high_threshold))
               || q_full;
  assign clr_c = thr_le(occ, low_threshold);

  assign pend_any   = pend_q | flush;
  assign idle_empty = q_empty && (state_q == IDLE);

  assign hs = (state_q == ISSUE) && wr.req_ready;

  // Uses the flag as it will be after this edge so a stop
  // threshold reached by the last pop does not start one more drain.
  assign want = drain_enable && !q_empty
             && (draining_d || pend_q || q_full);

  assign cont = drain_enable
             && (occ > REGISTER_SIZE'(1))
             && !lookup_req
             && (pend_q || q_full || (occ_m1 > low_threshold));

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    cnt_d       = cnt_q;
    draining_d  = set_c | (draining_q & ~clr_c);
    pend_d      = pend_any & ~idle_empty;
    done_d      = pend_any & idle_empty;
    unique case (state_q)
      IDLE: begin
        if (!(lookup_req && !q_full) && want) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d     = ISSUE;
        req_valid_d = 1'b1;
        req_data_d  = q_value;
      end
      ISSUE: begin
        if (hs) begin
          req_valid_d = 1'b0;
          cnt_d       = cnt_q + REGISTER_SIZE'(1);
          state_d     = cont ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      draining_q  <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      draining_q  <= draining_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign q_consumed   = hs;
  assign lookup_gnt   = lookup_req && (state_q != FETCH) && !reset;
  assign q_hit        = lookup_gnt;
  assign wr.req_valid = req_valid_q;
  assign wr.req_data  = req_data_q;
  assign draining     = draining_q;
  assign flush_done   = done_q;
  assign drain_count  = cnt_q;

endmodule

// File: doc/wb_drain_scheduler.md
Name: wb_drain_scheduler

Overview:
- Sequences the write-booster queue: decides when to drain entries to the downstream write port, pops the queue, and shares the queue's single BRAM read port between drain reads and hit lookups.
- Sits between the queue (data, occupancy, empty/full, consumed, hit/hitIndex) and the memory-side write channel.
- Draining uses threshold hysteresis plus an explicit flush.

Parameters:
- DATA_SIZE, 8, width of one queue entry.
- QUEUE_LENGTH, 4, queue depth in entries.
- REGISTER_SIZE, 32, width of threshold configuration registers.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- drain_enable  in  1  master enable; 0 means start no new drains.
- high_threshold  in  REGISTER_SIZE  occupancy at or above which draining starts; 0 disables threshold draining.
- low_threshold  in  REGISTER_SIZE  occupancy at or below which draining stops.
- flush  in  1  pulse: drain until empty, ignoring thresholds.
- flush_done  out  1  one-cycle pulse when a flush completes.
- q_count  in  $clog2(QUEUE_LENGTH)+1  queue occupancy.
- q_empty  in  1  queue empty.
- q_full  in  1  queue full.
- q_value  in  DATA_SIZE  queue read data (1-cycle BRAM read latency).
- q_consumed  out  1  pop strobe to queue.
- q_hit  out  1  drives queue hit-address select.
- lookup_req  in  1  requester wants a hitIndex read.
- lookup_gnt  out  1  lookup owns the read port this cycle.
- req_valid  out  1  write request valid.
- req_ready  in  1  downstream accepts.
- req_data  out  DATA_SIZE  write payload (registered).
- draining  out  1  hysteresis drain flag.
- drain_count  out  REGISTER_SIZE  entries drained since reset, wraps.

Behaviour:
- Reset values: req_valid=0, req_data=0, q_consumed=0, q_hit=0, lookup_gnt=0, draining=0, flush_done=0, drain_count=0, FSM=IDLE, flush_pending=0.
- Reset is asynchronous. An assertion mid-transfer drops req_valid immediately, and the entry is not popped.
- Threshold compare: zero-extend q_count to REGISTER_SIZE.
- draining sets (registered) when high_threshold!=0 && q_count>=high_threshold, or when q_full.
- draining clears when q_count<=low_threshold.
- Set wins if both conditions are true (misconfiguration with low>=high).
- flush sets flush_pending. flush_pending clears when q_empty is observed with FSM in IDLE; flush_done pulses 1 cycle that same edge.
- A flush while already empty gives flush_done on the next edge.
- want = drain_enable && !q_empty && (draining || flush_pending || q_full).
- FSM states:
  - IDLE: if lookup_req && !q_full, stay (lookup has priority). Else if want, go to FETCH.
  - FETCH: read head. q_hit=0 and lookup_gnt=0 are forced. Next edge captures req_data<=q_value and goes to ISSUE.
  - ISSUE: req_valid=1. req_data is held stable until req_ready.
- On handshake in ISSUE: q_consumed=1 combinationally that cycle, drain_count+1, go to FETCH if cont, else IDLE.
- cont = drain_enable && q_count>1 && !lookup_req && (flush_pending || q_full || q_count-1>low_threshold).
- cont uses the pre-pop q_count. A simultaneous queue push is accounted for by the queue, not by this block.
- Throughput: 1 entry per 2 cycles with req_ready tied high.
- lookup_gnt = lookup_req && state!=FETCH. q_hit = lookup_gnt.
- Lookup during ISSUE is allowed: the payload is already latched.
- q_full starvation rule: when full, a drain starts even with lookup_req. The lookup waits only for the FETCH cycle.
- drain_enable dropping during ISSUE: the transfer completes (valid never retracts), then the FSM returns to IDLE.
- flush during active drain: merges, and the drain continues until empty.
- q_consumed is never asserted outside an ISSUE handshake, so there is no pop when empty.

Decomposition:
- Package wb_sched_pkg:
  - state enum {IDLE, FETCH, ISSUE}.
  - localparam CNT_W = $clog2(QUEUE_LENGTH)+1.
  - function for zero-extended threshold compare.
- Single module; no sub-module warranted.

Test Plan:
- QUEUE_LENGTH=4, high=3, low=1, req_ready=1. Push 3 entries A,B,C: draining rises, outputs A then B with q_consumed pulses 2 cycles apart, stops with count=1, drain_count=2.
- Same config, req_ready low 5 cycles during ISSUE with A: req_valid and req_data=A stay stable, exactly one q_consumed, on ready.
- flush pulse with count=2, high=0: both entries drained, flush_done pulses once in the cycle the FSM returns to IDLE with q_empty=1.
- lookup_req held high with count=2 (not full): lookup_gnt=1 and q_hit=1 continuously, no drain. Fill to 4 (full): FETCH occurs, lookup_gnt=0 for exactly that cycle.
- Assert async reset while req_valid=1 with no clock edge: req_valid, q_consumed and draining go to 0 immediately, and the queue head is not advanced.
- drain_enable deasserted in ISSUE: the handshake still completes with one pop, then the FSM sits in IDLE with count above the threshold.
